// File: rtl/capture_readout.sv
// Read-side controller for the logic-analyzer sample buffer: walks the sample RAM from the
// oldest sample, packs two 4-bit samples per byte and streams them out; CHECKSUM_EN appends an XOR trailer byte.
module capture_readout #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_finish,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [3:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(DEPTH / 2 - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    LAT0  = 3'd2,
    RD1   = 3'd3,
    LAT1  = 3'd4,
    SEND  = 3'd5,
`ifdef CHECKSUM_EN
    TRAIL = 3'd6,
`endif
    FIN   = 3'd7
  } state_t;

  state_t              state_q;
  logic                wf_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   pair_cnt_q;
  logic [3:0]          lo_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                busy_q;
  logic                done_q;
`ifdef CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  // Buffer is DEPTH deep, which need not be a power of two, so wrap by compare.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wf_q       <= 1'b1;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      ptr_q      <= '0;
      pair_cnt_q <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      wf_q    <= write_finish;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (write_finish && !wf_q) begin
            ptr_q      <= start_addr;
            pair_cnt_q <= '0;
            rd_addr_q  <= start_addr;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
`ifdef CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
            state_q    <= RD0;
          end
        end
        RD0: begin
          ptr_q   <= next_ptr(ptr_q);
          state_q <= LAT0;
        end
        LAT0: begin
          lo_q      <= rd_data;
          rd_addr_q <= ptr_q;
          rd_en_q   <= 1'b1;
          state_q   <= RD1;
        end
        RD1: begin
          ptr_q   <= next_ptr(ptr_q);
          state_q <= LAT1;
        end
        LAT1: begin
          tx_data_q  <= {rd_data, lo_q};
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            pair_cnt_q <= pair_cnt_q + 1'b1;
            if (pair_cnt_q == LAST_PAIR) begin
`ifdef CHECKSUM_EN
              // Trailer is the running XOR including the byte just accepted.
              csum_q    <= csum_q ^ tx_data_q;
              tx_data_q <= csum_q ^ tx_data_q;
              state_q   <= TRAIL;
`else
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= FIN;
`endif
            end else begin
`ifdef CHECKSUM_EN
              csum_q     <= csum_q ^ tx_data_q;
`endif
              tx_valid_q <= 1'b0;
              rd_addr_q  <= ptr_q;
              rd_en_q    <= 1'b1;
              state_q    <= RD0;
            end
          end
        end
`ifdef CHECKSUM_EN
        TRAIL: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= FIN;
          end
        end
`endif
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout with DEPTH=8: scoreboarded bytes and read addresses against a small RAM model.
module tb_capture_readout;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              write_finish;
  logic [ADDR_W-1:0] start_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_cnt = 0;

  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic [3:0]        ram[DEPTH];

  capture_readout #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .write_finish(write_finish), .start_addr(start_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered sample RAM: data appears the cycle after the read strobe.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr[2:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) check("rd_unexpected", 32'(rd_addr), 32'hFFFF);
        else check("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF);
        else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input int sa);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int p = 0; p < DEPTH / 2; p++) begin
      int a0;
      int a1;
      a0 = (sa + 2 * p) % DEPTH;
      a1 = (sa + 2 * p + 1) % DEPTH;
      b = {ram[a1], ram[a0]};
      exp_q.push_back(b);
      addr_q.push_back(ADDR_W'(a0));
      addr_q.push_back(ADDR_W'(a1));
      x = x ^ b;
    end
`ifdef CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic kick(input int sa);
    write_finish = 1'b0;
    step(2);
    start_addr = ADDR_W'(sa);
    push_expect(sa);
    write_finish = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
    step(3);
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_left"}, 32'(exp_q.size() + addr_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int lat;
    int gap;
    int seen;
    logic rd_first;

    reset = 1'b1;
    write_finish = 1'b1;
    tx_ready = 1'b1;
    start_addr = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 4'(i);
    step(3);
    @(negedge clk);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);

    // write_finish held high through reset must not start a readout
    @(posedge clk); #1 reset = 1'b0;
    step(10);
    check("hold_busy", 32'(busy), 0);
    check("hold_rd", 32'(rd_cnt), 0);
    check("hold_done", 32'(done_cnt), 0);

    // Basic sequence with latency and throughput
    d0 = done_cnt;
    kick(0);
    lat = -1;
    rd_first = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 1) rd_first = rd_en;
      if (tx_valid) begin lat = n; break; end
    end
    check("rd0_strobe", 32'(rd_first), 1);
    check("first_valid_lat", 32'(lat), 32'd5);
    gap = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tx_valid) begin gap = n + 1; break; end
    end
    check("byte_period", 32'(gap), 32'd5);
    wait_done("seqA", d0);

    // Start near the end of the buffer: addresses wrap 7 -> 0
    d0 = done_cnt;
    kick(6);
    wait_done("wrap", d0);

    // Back-pressure during the first SEND
    tx_ready = 1'b0;
    d0 = done_cnt;
    kick(0);
    for (int n = 0; n < 30 && !tx_valid; n++) @(negedge clk);
    check("stall_seen", 32'(tx_valid), 1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("stall_valid", 32'(tx_valid), 1);
      check("stall_data", 32'(tx_data), 32'h10);
      check("stall_rd_en", 32'(rd_en), 0);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_done("stall", d0);

    // Extra write_finish edges while busy are ignored
    d0 = done_cnt;
    kick(2);
    step(7);
    write_finish = 1'b0; step(2);
    write_finish = 1'b1; step(2);
    write_finish = 1'b0; step(1);
    write_finish = 1'b1;
    wait_done("toggle", d0);
    step(30);
    check("toggle_once", 32'(done_cnt - d0), 32'd1);
    check("toggle_idle", 32'(busy), 0);

    // Reset during LAT1 of the second pair
    d0 = done_cnt;
    kick(0);
    seen = 0;
    for (int n = 0; n < 100 && seen < 4; n++) begin
      @(negedge clk);
      if (rd_en) seen++;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rd_en", 32'(rd_en), 0);
    check("mid_rst_rd_addr", 32'(rd_addr), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_tx_valid", 32'(tx_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    step(10);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_no_done", 32'(done_cnt - d0), 0);

    for (int i = 0; i < DEPTH; i++) ram[i] = 4'(i * 3 + 1);
    d0 = done_cnt;
    kick(5);
    wait_done("restart", d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
